// File: rtl/sv_uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX stream port among N_REQ requesters.
// Grants are held for a whole packet, followed by a programmable idle gap.
module sv_uart_tx_arbiter #(
   parameter int DATA_WIDTH = 24,
   parameter int N_REQ      = 4
) (
   input  logic                        iclk,
   input  logic                        irst,
   input  logic [N_REQ*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [N_REQ-1:0]            s_axis_tvalid,
   input  logic [N_REQ-1:0]            s_axis_tlast,
   output logic [N_REQ-1:0]            s_axis_tready,
   output logic [DATA_WIDTH-1:0]       m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   input  logic [15:0]                 igap,
   output logic [N_REQ-1:0]            ogrant,
   output logic                        obusy
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
      $error("sv_uart_tx_arbiter: N_REQ must be in 2..16");
   end
   if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("sv_uart_tx_arbiter: DATA_WIDTH must be a multiple of 8");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_GAP
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [N_REQ-1:0] r_grant;
   logic [N_REQ-1:0] w_grant_nxt;
   logic [IW-1:0]    r_last;
   logic [IW-1:0]    w_last_nxt;
   logic [15:0]      r_gap;
   logic [15:0]      w_gap_nxt;
   logic             r_busy;

   logic             w_req_found;
   logic [IW-1:0]    w_req_idx;
   logic [IW:0]      w_sum;
   logic             w_tlast;
   logic             w_fire;

   // Search starts one past the last winner and wraps around
   always_comb begin
      w_req_found = 1'b0;
      w_req_idx   = r_last;
      w_sum       = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         w_sum = {1'b0, r_last} + (IW+1)'(k);
         if (w_sum >= (IW+1)'(N_REQ)) begin
            w_sum = w_sum - (IW+1)'(N_REQ);
         end
         if (!w_req_found && s_axis_tvalid[w_sum[IW-1:0]]) begin
            w_req_found = 1'b1;
            w_req_idx   = w_sum[IW-1:0];
         end
      end
   end

   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      s_axis_tready = '0;
      w_tlast       = 1'b0;
      if (r_state == S_GRANT) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (r_grant[i]) begin
               m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
               m_axis_tvalid    = s_axis_tvalid[i];
               w_tlast          = s_axis_tlast[i];
               s_axis_tready[i] = m_axis_tready;
            end
         end
      end
   end

   assign w_fire = m_axis_tvalid & m_axis_tready;

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_last_nxt  = r_last;
      w_gap_nxt   = r_gap;
      unique case (r_state)
         S_IDLE: begin
            if (w_req_found) begin
               w_state_nxt            = S_GRANT;
               w_grant_nxt            = '0;
               w_grant_nxt[w_req_idx] = 1'b1;
               w_last_nxt             = w_req_idx;
            end
         end
         S_GRANT: begin
            if (w_fire && w_tlast) begin
               w_grant_nxt = '0;
               if (igap == 16'd0) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_GAP;
                  w_gap_nxt   = igap;
               end
            end
         end
         S_GAP: begin
            w_gap_nxt = r_gap - 16'd1;
            if (r_gap <= 16'd1) begin
               w_state_nxt = S_IDLE;
               w_gap_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge iclk) begin
      if (irst) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_last  <= IW'(N_REQ - 1);
         r_gap   <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_last  <= w_last_nxt;
         r_gap   <= w_gap_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
      end
   end

   assign ogrant = r_grant;
   assign obusy  = r_busy;

endmodule
